// File: rtl/mult32_seq.sv
// Sequential 32x32 shift-add multiplier for MIPS mult/multu.
// Fixed 34-cycle latency under a START/BUSY/DONE handshake.
module mult32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] sum;
  logic [63:0] prod;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    sum      = acc_q;
    prod     = {acc_q[31:0], mplier_q};

    case (state_q)
      IDLE: begin
        if (START) begin
          // Signed operands are reduced to magnitudes; the sign is reapplied at FIN.
          mcand_d  = (SIGNED && A[31]) ? (~A + 32'd1) : A;
          mplier_d = (SIGNED && B[31]) ? (~B + 32'd1) : B;
          neg_d    = SIGNED & (A[31] ^ B[31]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          sum = {1'b0, acc_q[31:0]} + {1'b0, mcand_q};
        end
        acc_d    = {1'b0, sum[32:1]};
        mplier_d = {sum[0], mplier_q[31:1]};
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = FIN;
        end
      end
      FIN: begin
        {hi_d, lo_d} = neg_q ? (~prod + 64'd1) : prod;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
